// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: CHAIN_LEN-bit scan register bank with a shift/capture pass controller.
// Optional MISR over unloaded scan data, enabled by defining MISR_EN.
`default_nettype none

module scan_chain_ctrl #(
  parameter int                CHAIN_LEN = 16,
  parameter int                CNT_W     = 5,
  parameter int                MISR_W    = 16,
  parameter logic [MISR_W-1:0] MISR_POLY = 16'h1021
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic [CHAIN_LEN-1:0] func_d,
  input  logic                 func_en,
  output logic [CHAIN_LEN-1:0] func_q,
  input  logic                 start,
  input  logic                 start_cap,
  input  logic                 scan_input,
  output logic                 scan_output,
  output logic                 scan_valid,
  output logic                 busy,
  output logic                 done,
  input  logic                 misr_clr,
  output logic [MISR_W-1:0]    misr_sig
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   cap_q;
  logic [CHAIN_LEN-1:0]   chain_q;
  logic                   done_q;

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= 1'b0;
      chain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A scan request wins over a functional load in the same cycle.
          if (start) begin
            cap_q   <= start_cap;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end else if (func_en) begin
            chain_q <= func_d;
          end
        end
        SHIFT: begin
          chain_q <= {chain_q[CHAIN_LEN-2:0], scan_input};
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            if (cap_q) begin
              state_q <= CAPTURE;
            end else begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          chain_q <= func_d;
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign func_q      = chain_q;
  assign scan_output = chain_q[CHAIN_LEN-1];
  assign scan_valid  = (state_q == SHIFT);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;

`ifdef MISR_EN
  logic [MISR_W-1:0] misr_q;
  logic [MISR_W-1:0] misr_d;

  always_comb begin
    misr_d    = {misr_q[MISR_W-2:0], 1'b0} ^ (misr_q[MISR_W-1] ? MISR_POLY : '0);
    misr_d[0] = misr_d[0] ^ scan_output;
  end

  always_ff @(posedge CK) begin
    if (RST || misr_clr) begin
      misr_q <= '0;
    end else if (state_q == SHIFT) begin
      misr_q <= misr_d;
    end
  end

  assign misr_sig = misr_q;
`else
  logic unused_misr_clr;
  assign unused_misr_clr = misr_clr;
  assign misr_sig        = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_scan_chain_ctrl.sv
// Self-checking bench for scan_chain_ctrl (CHAIN_LEN=4): vector table, directed passes, random passes.
`default_nettype none

module tb_scan_chain_ctrl;

  logic        CK = 1'b0;
  logic        RST;
  logic [3:0]  func_d;
  logic        func_en;
  logic [3:0]  func_q;
  logic        start;
  logic        start_cap;
  logic        scan_input;
  logic        scan_output;
  logic        scan_valid;
  logic        busy;
  logic        done;
  logic        misr_clr;
  logic [15:0] misr_sig;

  scan_chain_ctrl #(
    .CHAIN_LEN(4),
    .CNT_W    (3),
    .MISR_W   (16),
    .MISR_POLY(16'h1021)
  ) dut (
    .CK         (CK),
    .RST        (RST),
    .func_d     (func_d),
    .func_en    (func_en),
    .func_q     (func_q),
    .start      (start),
    .start_cap  (start_cap),
    .scan_input (scan_input),
    .scan_output(scan_output),
    .scan_valid (scan_valid),
    .busy       (busy),
    .done       (done),
    .misr_clr   (misr_clr),
    .misr_sig   (misr_sig)
  );

  always #5 CK = ~CK;

  int total = 0;
  int bad   = 0;

  logic [3:0]  model_q;
  logic [15:0] model_misr;

  typedef struct {
    logic       en;
    logic [3:0] d;
    logic [3:0] exp_q;
  } load_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  function automatic logic [15:0] misr_ref(input logic [15:0] m, input logic b);
    logic [15:0] r;
    r = m << 1;
    if (m[15]) r = r ^ 16'h1021;
    r[0] = r[0] ^ b;
    return r;
  endfunction

  function automatic logic [15:0] exp_misr();
`ifdef MISR_EN
    return model_misr;
`else
    return 16'h0000;
`endif
  endfunction

  // Runs one pass starting in the current cycle; returns in the done cycle.
  // sin[k] is the bit driven on shift cycle k.
  task automatic do_pass(input logic cap, input logic [3:0] sin, input logic [3:0] capd);
    logic [3:0] pre;
    pre        = model_q;
    start      = 1'b1;
    start_cap  = cap;
    func_en    = 1'b1;
    func_d     = 4'hF;
    scan_input = 1'($urandom);
    step();
    for (int k = 0; k < 4; k++) begin
      check("shift_valid", 32'(scan_valid), 32'd1);
      check("shift_busy", 32'(busy), 32'd1);
      check("shift_done", 32'(done), 32'd0);
      check("shift_sout", 32'(scan_output), 32'(pre[3-k]));
      if (k == 0) check("no_load_on_start", 32'(func_q), 32'(pre));
      model_misr = misr_ref(model_misr, pre[3-k]);
      scan_input = sin[k];
      start      = (k == 1) ? 1'b1 : 1'($urandom);
      start_cap  = 1'($urandom);
      func_en    = 1'($urandom);
      func_d     = 4'($urandom);
      step();
    end
    start   = 1'b0;
    func_en = 1'b0;
    if (cap) begin
      check("cap_busy", 32'(busy), 32'd1);
      check("cap_valid", 32'(scan_valid), 32'd0);
      check("cap_done", 32'(done), 32'd0);
      func_d = capd;
      step();
      model_q = capd;
    end else begin
      model_q = {sin[0], sin[1], sin[2], sin[3]};
    end
    check("pass_done", 32'(done), 32'd1);
    check("pass_busy", 32'(busy), 32'd0);
    check("pass_valid", 32'(scan_valid), 32'd0);
    check("pass_func_q", 32'(func_q), 32'(model_q));
    check("pass_sout", 32'(scan_output), 32'(model_q[3]));
    check("pass_misr", 32'(misr_sig), 32'(exp_misr()));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    load_vec_t vecs[6];
    vecs[0] = '{en: 1'b1, d: 4'hA, exp_q: 4'hA};
    vecs[1] = '{en: 1'b0, d: 4'h3, exp_q: 4'hA};
    vecs[2] = '{en: 1'b1, d: 4'h5, exp_q: 4'h5};
    vecs[3] = '{en: 1'b0, d: 4'hF, exp_q: 4'h5};
    vecs[4] = '{en: 1'b1, d: 4'h0, exp_q: 4'h0};
    vecs[5] = '{en: 1'b1, d: 4'hC, exp_q: 4'hC};

    // Reset with arbitrary inputs
    RST        = 1'b1;
    func_d     = 4'($urandom);
    func_en    = 1'b1;
    start      = 1'b1;
    start_cap  = 1'b1;
    scan_input = 1'b1;
    misr_clr   = 1'b0;
    step();
    step();
    check("rst_func_q", 32'(func_q), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(scan_valid), 32'd0);
    check("rst_sout", 32'(scan_output), 32'd0);
    check("rst_misr", 32'(misr_sig), 32'd0);
    RST       = 1'b0;
    start     = 1'b0;
    func_en   = 1'b0;
    start_cap = 1'b0;
    model_q    = 4'h0;
    model_misr = 16'h0000;

    // Functional load table
    for (int i = 0; i < 6; i++) begin
      func_en = vecs[i].en;
      func_d  = vecs[i].d;
      step();
      check("load_func_q", 32'(func_q), 32'(vecs[i].exp_q));
      check("load_busy", 32'(busy), 32'd0);
    end
    func_en = 1'b0;
    model_q = 4'hC;

    // Shift-only pass from 4'hA, scan_input 1,0,0,1
    func_en = 1'b1;
    func_d  = 4'hA;
    step();
    func_en  = 1'b0;
    misr_clr = 1'b1;
    step();
    misr_clr   = 1'b0;
    model_q    = 4'hA;
    model_misr = 16'h0000;
    do_pass(1'b0, 4'b1001, 4'h0);
    check("spec_shift_q", 32'(func_q), 32'h9);
`ifdef MISR_EN
    check("spec_shift_misr", 32'(misr_sig), 32'h000A);
`else
    check("spec_shift_misr", 32'(misr_sig), 32'h0000);
`endif
    step();
    check("done_one_cycle", 32'(done), 32'd0);

    // Capture pass
    do_pass(1'b1, 4'b0000, 4'h5);
    check("spec_cap_q", 32'(func_q), 32'h5);
    step();
    check("cap_done_one_cycle", 32'(done), 32'd0);
    check("cap_hold_q", 32'(func_q), 32'h5);

    // Reset in cycle 2 of a pass
    start     = 1'b1;
    start_cap = 1'b1;
    step();
    start = 1'b0;
    step();
    check("mid_busy_before", 32'(busy), 32'd1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_q", 32'(func_q), 32'd0);
    check("mid_rst_valid", 32'(scan_valid), 32'd0);
    check("mid_rst_misr", 32'(misr_sig), 32'd0);
    model_q    = 4'h0;
    model_misr = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      check("mid_rst_no_done", 32'(done), 32'd0);
      step();
    end

    // Random passes and loads, passes chained back-to-back from the done cycle
    for (int it = 0; it < 40; it++) begin
      int sel;
      sel = $urandom_range(0, 2);
      if (sel == 0) begin
        func_en  = 1'b1;
        func_d   = 4'($urandom);
        misr_clr = 1'($urandom);
        step();
        model_q = func_d;
`ifdef MISR_EN
        if (misr_clr) model_misr = 16'h0000;
`endif
        func_en  = 1'b0;
        misr_clr = 1'b0;
        check("rnd_load_q", 32'(func_q), 32'(model_q));
        check("rnd_load_misr", 32'(misr_sig), 32'(exp_misr()));
      end else begin
        do_pass(1'($urandom), 4'($urandom), 4'($urandom));
      end
    end
    step();
    check("final_done_low", 32'(done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
